branch_pc_ctrl: RTL and testbench
=================================

Name: branch_pc_ctrl

Overview:
- Consumes `o_br_less`/`o_br_equal` from the branch comparator and decides branch/jump outcome.
- Owns the architectural PC register and the fetch request handshake toward instruction memory.
- Drives the comparator's unsigned-select input from the decoded funct3.
- Sits between decode/regfile/comparator and the IMEM fetch port of the RV32I core.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset and on trap clear.
- CNT_W, 32, width of the taken-branch performance counter.

Ports:
- i_clk  in  1  core clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_instr_vld  in  1  decoded instruction for current PC is valid (one-cycle strobe)
- i_is_br  in  1  instruction is a conditional branch
- i_is_jal  in  1  instruction is JAL
- i_is_jalr  in  1  instruction is JALR
- i_funct3  in  3  instruction funct3
- i_br_less  in  1  less-than result from comparator
- i_br_equal  in  1  equal result from comparator
- o_br_un  out  1  to comparator: 1 = unsigned compare
- i_imm  in  32  sign-extended immediate
- i_rs1_data  in  32  rs1 operand (JALR base)
- o_pc  out  32  current PC
- o_pc_four  out  32  o_pc + 4 (link value)
- o_fetch_req  out  1  fetch request to IMEM
- i_fetch_ack  in  1  IMEM has returned the instruction at o_pc
- o_redirect  out  1  one-cycle pulse: control transfer taken
- o_misalign  out  1  sticky misaligned-target trap flag
- i_trap_clr  in  1  clear trap, restart at RESET_PC
- o_br_taken_cnt  out  CNT_W  count of taken conditional branches

Behaviour:
- Reset (async, i_reset=1):
  - Register outputs: o_pc=RESET_PC, state=S_FETCH, o_misalign=0, o_redirect=0, o_br_taken_cnt=0.
  - o_fetch_req follows state and is therefore 1.
- Combinational outputs:
  - o_br_un = i_funct3[1], driven regardless of state.
  - o_pc_four = o_pc + 4, mod 2^32.
- Taken decode (only when i_is_br):
  - 000 equal; 001 !equal.
  - 100 less; 101 !less.
  - 110 less; 111 !less.
  - 010/011 never taken.
- Target:
  - Branch/JAL: o_pc + i_imm.
  - JALR: (i_rs1_data + i_imm) & ~32'h1.
  - All additions wrap mod 2^32.
  - next_pc = target if (jal | jalr | branch taken), else o_pc + 4.
- Priority when more than one of is_br/is_jal/is_jalr is set: jalr > jal > br.
- FSM:
  - S_FETCH: o_fetch_req=1. On i_fetch_ack → S_EXEC. Ack in the reset-release cycle is honoured from the next edge.
  - S_EXEC: o_fetch_req=0. i_instr_vld is ignored in every other state. On i_instr_vld:
    - If a control transfer is taken and target[1]=1: o_misalign<=1, o_pc held, → S_TRAP. No redirect, no counter increment.
    - Otherwise: o_pc<=next_pc, → S_FETCH. o_redirect=1 for exactly this cycle's next edge if taken. o_br_taken_cnt increments if it is a taken conditional branch.
  - S_TRAP: all inputs except i_trap_clr ignored. On i_trap_clr: o_pc<=RESET_PC, o_misalign<=0, → S_FETCH.
- Latency: PC update one clock after the i_instr_vld cycle. Minimum 2 cycles per instruction with single-cycle ack.
- o_br_taken_cnt saturates at all-ones; no wrap.
- i_trap_clr outside S_TRAP has no effect.
- Reset mid-fetch or mid-exec immediately returns to reset values. A pending ack is discarded.

Decomposition:
- Shared package core_pkg:
  - FSM state typedef (S_FETCH, S_EXEC, S_TRAP).
  - funct3 constants (F3_BEQ … F3_BGEU).
  - RESET_PC default constant.
- One sub-module, br_decide: combinational funct3 + less/equal → taken.
- PC register, FSM and counter stay in the top module.

Test Plan:
- Reset then ack at cycle 2 → o_pc=0, o_fetch_req 1→0 after ack; with i_instr_vld, no branch → o_pc=4, o_redirect=0.
- BEQ at pc=0x100, imm=0x20, equal=1 → o_pc=0x120, o_redirect pulses 1 cycle, o_br_taken_cnt=1; same with equal=0 → o_pc=0x104, count unchanged.
- BLTU (funct3=110), o_br_un=1 checked, less=1, imm=-8 at pc=0x10 → o_pc=0x8; BGE funct3=101 with less=1 → not taken, o_br_un=0.
- JALR rs1=0x1003, imm=0 → o_pc=0x1002 is misaligned → o_misalign=1, o_pc held, state S_TRAP; i_trap_clr → o_pc=RESET_PC, o_misalign=0, o_fetch_req=1.
- JALR rs1=0x1001, imm=3 → target 0x1004, aligned, o_pc=0x1004, o_redirect=1; JAL pc=0xFFFF_FFFC, imm=8 → wrap to 0x4.
- Preload counter to all-ones (force), taken branch → counter stays all-ones; assert i_reset mid-S_EXEC → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared FSM state encoding, branch funct3 codes and reset PC default.
package core_pkg;
    typedef logic [1:0] state_t;
    localparam state_t S_FETCH = 2'd0;
    localparam state_t S_EXEC  = 2'd1;
    localparam state_t S_TRAP  = 2'd2;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
endpackage

// File: rtl/branch_pc_ctrl_if.sv
// branch_pc_ctrl_if: decode/comparator/IMEM signals of the PC controller.
interface branch_pc_ctrl_if #(parameter int CNT_W = 32);
    logic             i_instr_vld;
    logic             i_is_br;
    logic             i_is_jal;
    logic             i_is_jalr;
    logic [2:0]       i_funct3;
    logic             i_br_less;
    logic             i_br_equal;
    logic             o_br_un;
    logic [31:0]      i_imm;
    logic [31:0]      i_rs1_data;
    logic [31:0]      o_pc;
    logic [31:0]      o_pc_four;
    logic             o_fetch_req;
    logic             i_fetch_ack;
    logic             o_redirect;
    logic             o_misalign;
    logic             i_trap_clr;
    logic [CNT_W-1:0] o_br_taken_cnt;
    modport slave (
        input  i_instr_vld, i_is_br, i_is_jal, i_is_jalr, i_funct3, i_br_less, i_br_equal,
               i_imm, i_rs1_data, i_fetch_ack, i_trap_clr,
        output o_br_un, o_pc, o_pc_four, o_fetch_req, o_redirect, o_misalign, o_br_taken_cnt
    );
    modport master (
        output i_instr_vld, i_is_br, i_is_jal, i_is_jalr, i_funct3, i_br_less, i_br_equal,
               i_imm, i_rs1_data, i_fetch_ack, i_trap_clr,
        input  o_br_un, o_pc, o_pc_four, o_fetch_req, o_redirect, o_misalign, o_br_taken_cnt
    );
endinterface

// File: rtl/br_decide.sv
// br_decide: conditional-branch outcome from funct3 and comparator flags.
module br_decide
    import core_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_less,
    input  logic       i_equal,
    output logic       o_taken
);
    // funct3[0] inverts the base condition; 010/011 are not branches
    assign o_taken = i_funct3[2] ? (i_less ^ i_funct3[0])
                   : (!i_funct3[1] && (i_equal ^ i_funct3[0]));
endmodule

// File: rtl/branch_pc_ctrl.sv
// branch_pc_ctrl: PC register, fetch handshake FSM and branch/jump resolution.
module branch_pc_ctrl
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic i_clk,
    input  logic i_reset,
    branch_pc_ctrl_if.slave bus
);
    state_t           r_state;
    logic [31:0]      r_pc;
    logic             r_redirect;
    logic             r_misalign;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cond;
    logic             w_br_taken;
    logic             w_xfer;
    logic [31:0]      w_target;
    logic [31:0]      w_next_pc;
    br_decide u_br_decide (
        .i_funct3 (bus.i_funct3),
        .i_less   (bus.i_br_less),
        .i_equal  (bus.i_br_equal),
        .o_taken  (w_cond)
    );
    // jumps outrank the branch flag, so only a pure branch is counted
    assign w_br_taken = bus.i_is_br && !bus.i_is_jal && !bus.i_is_jalr && w_cond;
    assign w_xfer     = bus.i_is_jal || bus.i_is_jalr || w_br_taken;
    assign w_target   = bus.i_is_jalr ? ((bus.i_rs1_data + bus.i_imm) & ~32'h1) : (r_pc + bus.i_imm);
    assign w_next_pc  = w_xfer ? w_target : r_pc + 32'd4;
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_FETCH;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_redirect <= 1'b0;
            if (r_state == S_FETCH) begin
                if (bus.i_fetch_ack) r_state <= S_EXEC;
            end else if (r_state == S_EXEC) begin
                if (bus.i_instr_vld && w_xfer && w_target[1]) begin
                    r_misalign <= 1'b1;
                    r_state    <= S_TRAP;
                end else if (bus.i_instr_vld) begin
                    r_pc       <= w_next_pc;
                    r_redirect <= w_xfer;
                    r_state    <= S_FETCH;
                    if (w_br_taken && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
                end
            end else if (bus.i_trap_clr) begin
                r_pc       <= RESET_PC;
                r_misalign <= 1'b0;
                r_state    <= S_FETCH;
            end
        end
    end
    assign bus.o_br_un        = bus.i_funct3[1];
    assign bus.o_pc           = r_pc;
    assign bus.o_pc_four      = r_pc + 32'd4;
    assign bus.o_fetch_req    = (r_state == S_FETCH);
    assign bus.o_redirect     = r_redirect;
    assign bus.o_misalign     = r_misalign;
    assign bus.o_br_taken_cnt = r_cnt;
endmodule

// File: tb/tb_branch_pc_ctrl.sv
// tb_branch_pc_ctrl: directed vectors with hand-computed PC/flag/counter expectations.
module tb_branch_pc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    branch_pc_ctrl_if #(.CNT_W(32)) bus ();
    branch_pc_ctrl #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
    endtask
    task automatic idle();
        bus.i_instr_vld = 0; bus.i_is_br = 0; bus.i_is_jal = 0; bus.i_is_jalr = 0;
        bus.i_funct3 = 3'b010; bus.i_br_less = 0; bus.i_br_equal = 0;
        bus.i_imm = 0; bus.i_rs1_data = 0; bus.i_fetch_ack = 0; bus.i_trap_clr = 0;
    endtask
    // fetch-ack then present one decoded instruction; outputs are sampled after the update edge
    task automatic exec(input logic br, input logic jal, input logic jalr, input logic [2:0] f3,
                        input logic less, input logic eq, input logic [31:0] imm, input logic [31:0] rs1);
        check("fetch_req_pre", bus.o_fetch_req, 1);
        bus.i_fetch_ack = 1;
        step();
        bus.i_fetch_ack = 0;
        check("fetch_req_exec", bus.o_fetch_req, 0);
        bus.i_instr_vld = 1; bus.i_is_br = br; bus.i_is_jal = jal; bus.i_is_jalr = jalr;
        bus.i_funct3 = f3; bus.i_br_less = less; bus.i_br_equal = eq;
        bus.i_imm = imm; bus.i_rs1_data = rs1;
        step();
        idle();
    endtask
    initial begin
        idle();
        #3;
        check("rst_pc", bus.o_pc, 0);
        check("rst_fetch_req", bus.o_fetch_req, 1);
        check("rst_misalign", bus.o_misalign, 0);
        check("rst_redirect", bus.o_redirect, 0);
        check("rst_cnt", bus.o_br_taken_cnt, 0);
        step();
        rst = 0;
        step();
        exec(0, 0, 0, 3'b000, 0, 0, 32'h0, 32'h0);
        check("seq_pc", bus.o_pc, 32'h4);
        check("seq_redirect", bus.o_redirect, 0);
        exec(0, 1, 0, 3'b000, 0, 0, 32'hFC, 32'h0);
        check("jal_pc", bus.o_pc, 32'h100);
        check("jal_redirect", bus.o_redirect, 1);
        check("jal_cnt", bus.o_br_taken_cnt, 0);
        exec(1, 0, 0, 3'b000, 0, 1, 32'h20, 32'h0);
        check("beq_t_pc", bus.o_pc, 32'h120);
        check("beq_t_redirect", bus.o_redirect, 1);
        check("beq_t_cnt", bus.o_br_taken_cnt, 1);
        step();
        check("redirect_one_cycle", bus.o_redirect, 0);
        exec(1, 0, 0, 3'b000, 0, 0, 32'h20, 32'h0);
        check("beq_nt_pc", bus.o_pc, 32'h124);
        check("beq_nt_redirect", bus.o_redirect, 0);
        check("beq_nt_cnt", bus.o_br_taken_cnt, 1);
        exec(0, 1, 0, 3'b000, 0, 0, 32'hFFFF_FEEC, 32'h0);
        check("jal_back_pc", bus.o_pc, 32'h10);
        bus.i_funct3 = 3'b110;
        #1 check("bltu_un", bus.o_br_un, 1);
        bus.i_funct3 = 3'b101;
        #1 check("bge_un", bus.o_br_un, 0);
        step();
        exec(1, 0, 0, 3'b110, 1, 0, 32'hFFFF_FFF8, 32'h0);
        check("bltu_pc", bus.o_pc, 32'h8);
        check("bltu_cnt", bus.o_br_taken_cnt, 2);
        exec(1, 0, 0, 3'b101, 1, 0, 32'h40, 32'h0);
        check("bge_nt_pc", bus.o_pc, 32'hC);
        check("bge_nt_cnt", bus.o_br_taken_cnt, 2);
        exec(1, 0, 0, 3'b010, 1, 1, 32'h40, 32'h0);
        check("f3_010_pc", bus.o_pc, 32'h10);
        exec(0, 0, 1, 3'b000, 0, 0, 32'h0, 32'h1003);
        check("mis_flag", bus.o_misalign, 1);
        check("mis_pc_held", bus.o_pc, 32'h10);
        check("mis_redirect", bus.o_redirect, 0);
        check("mis_fetch_req", bus.o_fetch_req, 0);
        check("mis_cnt", bus.o_br_taken_cnt, 2);
        bus.i_fetch_ack = 1; bus.i_instr_vld = 1; bus.i_is_jal = 1; bus.i_imm = 32'h40;
        step();
        idle();
        check("trap_ignores_pc", bus.o_pc, 32'h10);
        check("trap_ignores_req", bus.o_fetch_req, 0);
        bus.i_trap_clr = 1;
        step();
        bus.i_trap_clr = 0;
        check("clr_pc", bus.o_pc, 32'h0);
        check("clr_misalign", bus.o_misalign, 0);
        check("clr_fetch_req", bus.o_fetch_req, 1);
        exec(0, 0, 1, 3'b000, 0, 0, 32'h3, 32'h1001);
        check("jalr_pc", bus.o_pc, 32'h1004);
        check("jalr_redirect", bus.o_redirect, 1);
        exec(0, 1, 0, 3'b000, 0, 0, 32'hFFFF_EFF8, 32'h0);
        check("jal_top_pc", bus.o_pc, 32'hFFFF_FFFC);
        check("pc_four_wrap", bus.o_pc_four, 32'h0);
        exec(0, 1, 0, 3'b000, 0, 0, 32'h8, 32'h0);
        check("jal_wrap_pc", bus.o_pc, 32'h4);
        exec(1, 1, 1, 3'b000, 0, 1, 32'h0, 32'h200);
        check("prio_jalr_pc", bus.o_pc, 32'h200);
        check("prio_cnt", bus.o_br_taken_cnt, 2);
        bus.i_trap_clr = 1;
        step();
        bus.i_trap_clr = 0;
        check("clr_outside_trap", bus.o_pc, 32'h200);
        force dut.r_cnt = '1;
        #1 release dut.r_cnt;
        exec(1, 0, 0, 3'b001, 0, 0, 32'h8, 32'h0);
        check("sat_pc", bus.o_pc, 32'h208);
        check("sat_cnt", bus.o_br_taken_cnt, 32'hFFFF_FFFF);
        bus.i_fetch_ack = 1;
        step();
        bus.i_fetch_ack = 0;
        check("pre_rst_exec", bus.o_fetch_req, 0);
        #2 rst = 1;
        #1;
        check("arst_pc", bus.o_pc, 0);
        check("arst_fetch_req", bus.o_fetch_req, 1);
        check("arst_cnt", bus.o_br_taken_cnt, 0);
        check("arst_misalign", bus.o_misalign, 0);
        check("arst_redirect", bus.o_redirect, 0);
        step();
        rst = 0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
